smem_row_feeder: RTL and testbench

//  Upstream stage of smem_writer_hsi. Packs a DW-bit AXI-stream (4 beats = one 256-byte SMEM row)

---
 rtl/smem_row_feeder_pkg.sv | 22 ++
 rtl/smem_row_feeder_pingpong.sv | 75 +++++++
 rtl/smem_row_feeder.sv | 156 +++++++++++++++
 tb/tb_smem_row_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_row_feeder_pkg.sv
// Shared constants and state encodings for the SMEM row feeder.
// A row is ROW_BEATS stream beats; job and issue FSMs use the enums below.
package smem_row_feeder_pkg;

    localparam int unsigned ROW_BEATS       = 4;
    localparam int unsigned ENTRIES_PER_ROW = 64;
    localparam int unsigned ROW_BYTES       = 256;
    localparam int unsigned BEAT_W          = $clog2(ROW_BEATS);

    typedef enum logic [1:0] {
        JobIdle,
        JobRun,
        JobHold
    } job_state_e;

    typedef enum logic [1:0] {
        IssIdle,
        IssPulse,
        IssBusy
    } iss_state_e;

endpackage

// File: rtl/smem_row_feeder_pingpong.sv
// Two row buffers of ROW_BEATS x DW with fill/drain pointers and full flags.
// The read side always presents the buffer selected by the drain pointer.
module smem_row_feeder_pingpong
    import smem_row_feeder_pkg::*;
#(
    parameter int unsigned DW = 512
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic                         rd_release_i,
    output logic                         wr_full_o,
    output logic                         rd_full_o,
    output logic                         row_filled_o,
    output logic [ROW_BEATS-1:0][DW-1:0] seg_o
);

    logic [ROW_BEATS-1:0][DW-1:0] mem_q [2];
    logic [1:0]                   full_q, full_d;
    logic                         wr_buf_q, wr_buf_d;
    logic                         rd_buf_q, rd_buf_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic                         wr_accept;
    logic                         rd_accept;

    // A full buffer is never written, so fill and drain always target different buffers.
    assign wr_accept    = wr_en_i & ~full_q[wr_buf_q];
    assign rd_accept    = rd_release_i & full_q[rd_buf_q];
    assign row_filled_o = wr_accept & (beat_q == BEAT_W'(ROW_BEATS - 1));
    assign wr_full_o    = full_q[wr_buf_q];
    assign rd_full_o    = full_q[rd_buf_q];
    assign seg_o        = mem_q[rd_buf_q];

    always_comb begin
        full_d   = full_q;
        wr_buf_d = wr_buf_q;
        rd_buf_d = rd_buf_q;
        beat_d   = beat_q;
        if (wr_accept) begin
            if (row_filled_o) begin
                full_d[wr_buf_q] = 1'b1;
                wr_buf_d         = ~wr_buf_q;
                beat_d           = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        if (rd_accept) begin
            full_d[rd_buf_q] = 1'b0;
            rd_buf_d         = ~rd_buf_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q   <= '0;
            wr_buf_q <= 1'b0;
            rd_buf_q <= 1'b0;
            beat_q   <= '0;
        end else begin
            full_q   <= full_d;
            wr_buf_q <= wr_buf_d;
            rd_buf_q <= rd_buf_d;
            beat_q   <= beat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_buf_q][beat_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/smem_row_feeder.sv
// Packs stream beats into ping-pong rows and hands each row to the SMEM writer.
// Job FSM tracks the job; issue FSM pulses start and waits for the writer to return ready.
module smem_row_feeder
    import smem_row_feeder_pkg::*;
#(
    parameter int unsigned DW           = 512,
    parameter int unsigned DONE_HOLDOFF = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cfg_start,
    input  logic [31:0]   cfg_first_row,
    input  logic [31:0]   cfg_row_count,
    output logic          busy,
    output logic          complete,
    input  logic [DW-1:0] axis_tdata,
    input  logic          axis_tvalid,
    output logic          axis_tready,
    output logic [DW-1:0] smem_data0,
    output logic [DW-1:0] smem_data1,
    output logic [DW-1:0] smem_data2,
    output logic [DW-1:0] smem_data3,
    output logic [31:0]   row_index,
    output logic          start,
    input  logic          ready,
    input  logic          done
);

    job_state_e job_q, job_d;
    iss_state_e iss_q, iss_d;
    logic [31:0] first_q, first_d;
    logic [31:0] count_q, count_d;
    logic [31:0] rows_in_q, rows_in_d;
    logic [31:0] rows_out_q, rows_out_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] row_index_q, row_index_d;
    logic        start_q, start_d;

    logic                         wr_full, rd_full, row_filled, release_row;
    logic [ROW_BEATS-1:0][DW-1:0] seg;

    assign release_row = (iss_q == IssBusy) & ready;
    assign start_d     = (iss_d == IssPulse);

    smem_row_feeder_pingpong #(
        .DW(DW)
    ) u_pingpong (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .wr_en_i      (axis_tvalid & axis_tready),
        .wr_data_i    (axis_tdata),
        .rd_release_i (release_row),
        .wr_full_o    (wr_full),
        .rd_full_o    (rd_full),
        .row_filled_o (row_filled),
        .seg_o        (seg)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            job_q       <= JobIdle;
            iss_q       <= IssIdle;
            first_q     <= '0;
            count_q     <= '0;
            rows_in_q   <= '0;
            rows_out_q  <= '0;
            hold_q      <= '0;
            row_index_q <= '0;
            start_q     <= 1'b0;
        end else begin
            job_q       <= job_d;
            iss_q       <= iss_d;
            first_q     <= first_d;
            count_q     <= count_d;
            rows_in_q   <= rows_in_d;
            rows_out_q  <= rows_out_d;
            hold_q      <= hold_d;
            row_index_q <= row_index_d;
            start_q     <= start_d;
        end
    end

    always_comb begin
        job_d       = job_q;
        iss_d       = iss_q;
        first_d     = first_q;
        count_d     = count_q;
        rows_in_d   = rows_in_q;
        rows_out_d  = rows_out_q;
        hold_d      = hold_q;
        row_index_d = row_index_q;

        unique case (job_q)
            JobIdle: begin
                if (cfg_start) begin
                    job_d      = JobRun;
                    first_d    = cfg_first_row;
                    count_d    = cfg_row_count;
                    rows_in_d  = '0;
                    rows_out_d = '0;
                end
            end
            JobRun: begin
                if (rows_out_q == count_q) begin
                    job_d  = JobHold;
                    hold_d = 32'(DONE_HOLDOFF);
                end
            end
            JobHold: begin
                // The writer's done lags through its synchroniser; ignore it until the holdoff drains.
                if (hold_q != '0) begin
                    hold_d = hold_q - 32'd1;
                end else if (done) begin
                    job_d = JobIdle;
                end
            end
            default: job_d = JobIdle;
        endcase

        unique case (iss_q)
            IssIdle: begin
                if ((job_q == JobRun) && rd_full && ready) begin
                    row_index_d = first_q + rows_out_q;
                    iss_d       = IssPulse;
                end
            end
            IssPulse: iss_d = IssBusy;
            IssBusy: begin
                if (ready) begin
                    iss_d = IssIdle;
                end
            end
            default: iss_d = IssIdle;
        endcase

        if (row_filled) begin
            rows_in_d = rows_in_q + 32'd1;
        end
        if (release_row) begin
            rows_out_d = rows_out_q + 32'd1;
        end
    end

    always_comb begin
        busy        = (job_q != JobIdle);
        complete    = (job_q == JobHold) && (hold_q == '0) && done;
        axis_tready = (job_q == JobRun) && !wr_full && (rows_in_q < count_q);
        start       = start_q;
        row_index   = row_index_q;
        smem_data0  = seg[0];
        smem_data1  = seg[1];
        smem_data2  = seg[2];
        smem_data3  = seg[3];
    end

endmodule

// File: tb/tb_smem_row_feeder.sv
// Directed bench for smem_row_feeder with a latency-programmable writer model.
// Each task drives one scenario and checks its results inline.
module tb_smem_row_feeder;

    localparam int unsigned DW    = 32;
    localparam int unsigned HOLD  = 8;
    localparam int          LIMIT = 2000;

    logic          clk = 1'b0;
    logic          resetn, cfg_start, busy, complete, axis_tvalid, axis_tready;
    logic          start, ready, done;
    logic [31:0]   cfg_first_row, cfg_row_count, row_index;
    logic [DW-1:0] axis_tdata, d0, d1, d2, d3;

    int tests = 0;
    int fails = 0;

    // Writer model: busy for wlat cycles after each start, never ready during the pulse.
    int wlat = 0;
    int wcnt = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (start) wcnt <= wlat;
        else if (wcnt > 0) wcnt <= wcnt - 1;
    end
    assign ready = (wcnt == 0) && !start;

    smem_row_feeder #(
        .DW           (DW),
        .DONE_HOLDOFF (HOLD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_start     (cfg_start),
        .cfg_first_row (cfg_first_row),
        .cfg_row_count (cfg_row_count),
        .busy          (busy),
        .complete      (complete),
        .axis_tdata    (axis_tdata),
        .axis_tvalid   (axis_tvalid),
        .axis_tready   (axis_tready),
        .smem_data0    (d0),
        .smem_data1    (d1),
        .smem_data2    (d2),
        .smem_data3    (d3),
        .row_index     (row_index),
        .start         (start),
        .ready         (ready),
        .done          (done)
    );

    function automatic logic [DW-1:0] pat(input logic [7:0] tag, input int b);
        logic [31:0] bv;
        bv = b;
        return {tag, 8'h00, bv[15:0]};
    endfunction

    int          n_starts, n_complete, last_rel, done_rise, complete_cyc;
    int          max_buf, full_err, stable_err, pulse_err, tready_cnt;
    bit          timed_out;
    logic [31:0] st_idx [8];
    logic [DW-1:0] st_seg [8][4];
    logic        ab_start, ab_busy, ab_tready;
    logic [31:0] ab_idx;

    // Runs one job cycle by cycle, recording starts, buffer occupancy and completion timing.
    task automatic run_job(input logic [31:0] first, input int count, input logic [7:0] tag,
                           input int lat, input int done_delay, input bit done_always,
                           input int abort_start);
        int beat_idx = 0, released = 0, c = 0, buffered;
        bit acc_p = 0, rel_p = 0, in_flight = 0, prev_start = 0, stop = 0, abort_p = 0;
        logic [31:0] snap_idx;
        logic [DW-1:0] snap [4];
        n_starts = 0; n_complete = 0; last_rel = -1; done_rise = -1; complete_cyc = -1;
        max_buf = 0; full_err = 0; stable_err = 0; pulse_err = 0; tready_cnt = 0;
        snap_idx = '0;
        for (int k = 0; k < 4; k++) snap[k] = '0;
        wlat = lat;
        while (!stop && c < LIMIT) begin
            @(negedge clk);
            #1;
            if (acc_p) beat_idx++;
            if (rel_p) begin released++; last_rel = c - 1; end
            cfg_start     = (c == 0) && !abort_p;
            cfg_first_row = first;
            cfg_row_count = count;
            axis_tvalid   = (beat_idx < count * 4);
            axis_tdata    = pat(tag, beat_idx);
            done = done_always || (released == count && count > 0 && c - last_rel >= done_delay);
            if (done && done_rise < 0) done_rise = c;
            #1;
            if (abort_p) begin
                ab_start = start; ab_busy = busy; ab_tready = axis_tready; ab_idx = row_index;
                stop = 1;
            end else begin
                if (axis_tready) tready_cnt++;
                buffered = beat_idx - 4 * released;
                if (buffered > max_buf) max_buf = buffered;
                if (buffered >= 8 && axis_tready) full_err++;
                if (start && prev_start) pulse_err++;
                if (in_flight && !start) begin
                    if (row_index !== snap_idx || d0 !== snap[0] || d1 !== snap[1] ||
                        d2 !== snap[2] || d3 !== snap[3]) stable_err++;
                end
                if (start) begin
                    if (n_starts < 8) begin
                        st_idx[n_starts] = row_index;
                        st_seg[n_starts][0] = d0; st_seg[n_starts][1] = d1;
                        st_seg[n_starts][2] = d2; st_seg[n_starts][3] = d3;
                    end
                    n_starts++;
                    in_flight = 1;
                    snap_idx = row_index;
                    snap[0] = d0; snap[1] = d1; snap[2] = d2; snap[3] = d3;
                    if (n_starts == abort_start) begin resetn = 1'b0; abort_p = 1; end
                end
                rel_p = in_flight && !start && ready;
                if (rel_p) in_flight = 0;
                acc_p = axis_tvalid && axis_tready;
                prev_start = start;
                if (complete) begin
                    n_complete++;
                    if (complete_cyc < 0) complete_cyc = c;
                end
                if (complete_cyc >= 0 && c >= complete_cyc + 2) stop = 1;
            end
            c++;
        end
        timed_out = !stop;
        cfg_start = 1'b0; axis_tvalid = 1'b0; done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cfg_start = 1'b0; cfg_first_row = '0; cfg_row_count = '0;
        axis_tvalid = 1'b1; axis_tdata = '0; done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (complete !== 1'b0) begin fails++; $display("FAIL reset_complete got %b want 0", complete); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", start); end
        tests++; if (axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %b want 0", axis_tready); end
        tests++; if (row_index !== 32'h0) begin fails++; $display("FAIL reset_row_index got %h want 0", row_index); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (axis_tready !== 1'b0) begin fails++; $display("FAIL idle_tready got %b want 0", axis_tready); end
        axis_tvalid = 1'b0;
    endtask

    task automatic test_single_row();
        run_job(32'h10, 1, 8'hA1, 20, 15, 1'b0, 0);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL t1_timeout got %b want 0", timed_out); end
        tests++; if (n_starts !== 1) begin fails++; $display("FAIL t1_starts got %0d want 1", n_starts); end
        tests++; if (st_idx[0] !== 32'h10) begin fails++; $display("FAIL t1_row_index got %h want 10", st_idx[0]); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (st_seg[0][k] !== pat(8'hA1, k)) begin
                fails++; $display("FAIL t1_seg%0d got %h want %h", k, st_seg[0][k], pat(8'hA1, k));
            end
        end
        tests++; if (stable_err !== 0) begin fails++; $display("FAIL t1_hold got %0d changes want 0", stable_err); end
        tests++; if (pulse_err !== 0) begin fails++; $display("FAIL t1_pulse got %0d long pulses want 0", pulse_err); end
        tests++; if (n_complete !== 1) begin fails++; $display("FAIL t1_complete_cnt got %0d want 1", n_complete); end
        tests++; if (complete_cyc < done_rise) begin fails++; $display("FAIL t1_complete_before_done got %0d want >= %0d", complete_cyc, done_rise); end
        tests++; if (complete_cyc - last_rel < HOLD) begin fails++; $display("FAIL t1_holdoff got %0d want >= %0d", complete_cyc - last_rel, HOLD); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        run_job(32'h10, 3, 8'hB2, 70, 3, 1'b0, 0);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL t2_timeout got %b want 0", timed_out); end
        tests++; if (n_starts !== 3) begin fails++; $display("FAIL t2_starts got %0d want 3", n_starts); end
        for (int r = 0; r < 3; r++) begin
            tests++;
            if (st_idx[r] !== 32'h10 + r) begin
                fails++; $display("FAIL t2_row_index%0d got %h want %h", r, st_idx[r], 32'h10 + r);
            end
        end
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++)
                if (st_seg[r][k] !== pat(8'hB2, r * 4 + k)) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL t2_data got %0d bad segments want 0", bad); end
        tests++; if (max_buf !== 8) begin fails++; $display("FAIL t2_overlap got max %0d beats want 8", max_buf); end
        tests++; if (full_err !== 0) begin fails++; $display("FAIL t2_tready_full got %0d want 0", full_err); end
        tests++; if (stable_err !== 0) begin fails++; $display("FAIL t2_hold got %0d changes want 0", stable_err); end
        tests++; if (n_complete !== 1) begin fails++; $display("FAIL t2_complete_cnt got %0d want 1", n_complete); end
    endtask

    task automatic test_zero_rows();
        run_job(32'h30, 0, 8'hC3, 5, 0, 1'b1, 0);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL t3_timeout got %b want 0", timed_out); end
        tests++; if (n_starts !== 0) begin fails++; $display("FAIL t3_starts got %0d want 0", n_starts); end
        tests++; if (tready_cnt !== 0) begin fails++; $display("FAIL t3_tready got %0d cycles want 0", tready_cnt); end
        tests++;
        if (complete_cyc < HOLD + 1 || complete_cyc > HOLD + 3) begin
            fails++; $display("FAIL t3_complete_time got %0d want %0d..%0d", complete_cyc, HOLD + 1, HOLD + 3);
        end
        tests++; if (n_complete !== 1) begin fails++; $display("FAIL t3_complete_cnt got %0d want 1", n_complete); end
    endtask

    task automatic test_stale_done();
        run_job(32'h50, 1, 8'hD4, 10, 0, 1'b1, 0);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL t4_timeout got %b want 0", timed_out); end
        tests++; if (st_idx[0] !== 32'h50) begin fails++; $display("FAIL t4_row_index got %h want 50", st_idx[0]); end
        tests++;
        if (complete_cyc - last_rel < HOLD || complete_cyc - last_rel > HOLD + 3) begin
            fails++; $display("FAIL t4_holdoff got %0d want %0d..%0d", complete_cyc - last_rel, HOLD, HOLD + 3);
        end
    endtask

    task automatic test_wrap();
        run_job(32'hFFFF_FFFF, 2, 8'hE5, 5, 2, 1'b0, 0);
        tests++; if (n_starts !== 2) begin fails++; $display("FAIL t5_starts got %0d want 2", n_starts); end
        tests++; if (st_idx[0] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL t5_idx0 got %h want ffffffff", st_idx[0]); end
        tests++; if (st_idx[1] !== 32'h0) begin fails++; $display("FAIL t5_idx1 got %h want 0", st_idx[1]); end
        tests++; if (st_seg[1][3] !== pat(8'hE5, 7)) begin fails++; $display("FAIL t5_seg got %h want %h", st_seg[1][3], pat(8'hE5, 7)); end
    endtask

    task automatic test_abort();
        run_job(32'h60, 3, 8'hF6, 10, 2, 1'b0, 2);
        tests++; if (n_starts !== 2) begin fails++; $display("FAIL t6_reached got %0d starts want 2", n_starts); end
        tests++; if (ab_start !== 1'b0) begin fails++; $display("FAIL t6_start got %b want 0", ab_start); end
        tests++; if (ab_busy !== 1'b0) begin fails++; $display("FAIL t6_busy got %b want 0", ab_busy); end
        tests++; if (ab_tready !== 1'b0) begin fails++; $display("FAIL t6_tready got %b want 0", ab_tready); end
        tests++; if (ab_idx !== 32'h0) begin fails++; $display("FAIL t6_row_index got %h want 0", ab_idx); end
        repeat (20) @(negedge clk);
        resetn = 1'b1;
        run_job(32'h20, 1, 8'h17, 5, 2, 1'b0, 0);
        tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL t6_restart_timeout got %b want 0", timed_out); end
        tests++; if (n_starts !== 1) begin fails++; $display("FAIL t6_restart_starts got %0d want 1", n_starts); end
        tests++; if (st_idx[0] !== 32'h20) begin fails++; $display("FAIL t6_restart_idx got %h want 20", st_idx[0]); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (st_seg[0][k] !== pat(8'h17, k)) begin
                fails++; $display("FAIL t6_restart_seg%0d got %h want %h", k, st_seg[0][k], pat(8'h17, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_zero_rows();
        test_stale_done();
        test_wrap();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
